// File: rtl/que_dispatcher.sv
// Consumer side of the queue arbitration handshake: pulses update/clear to the
// arbiter and drains one packet per grant from the granted queue downstream.
module que_dispatcher #(
    parameter int PORTNUM  = 16,
    parameter int DW       = 32,
    parameter int MAXBEAT  = 256,
    parameter int WAIT_MAX = 4,
    localparam int PW = $clog2(PORTNUM),
    localparam int BW = $clog2(MAXBEAT),
    localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [PORTNUM-1:0] i_pending,
    output logic               o_update,
    output logic               o_clr_vld,
    output logic [PW-1:0]      o_clr_port,
    input  logic [PW-1:0]      i_arb_port,
    input  logic               i_arb_port_vld,
    input  logic               i_arb_empty,
    input  logic [PORTNUM-1:0] i_q_vld,
    input  logic [DW-1:0]      i_q_data [PORTNUM],
    input  logic [PORTNUM-1:0] i_q_last,
    output logic [PORTNUM-1:0] o_q_rdy,
    output logic               o_vld,
    output logic [DW-1:0]      o_data,
    output logic               o_last,
    output logic [PW-1:0]      o_port,
    input  logic               i_ready,
    output logic               o_busy,
    output logic [15:0]        o_pkt_cnt,
    output logic               o_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UPD  = 3'd1,
        S_WAIT = 3'd2,
        S_XFER = 3'd3,
        S_CLR  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   sel_q, sel_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [15:0]     pkt_cnt_q, pkt_cnt_d;
    logic            err_q, err_d;
    logic            accept;
    logic            wait_first;

    assign accept     = o_vld & i_ready;
    assign wait_first = (wait_cnt_q == '0);
    assign o_pkt_cnt  = pkt_cnt_q;
    assign o_err      = err_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            beat_cnt_q <= '0;
            wait_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (|i_pending) state_d = S_UPD;
            end
            S_UPD: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A grant seen together with empty in the first WAIT cycle is a stale snapshot.
                if (i_arb_port_vld && !(wait_first && i_arb_empty)) begin
                    sel_d      = i_arb_port;
                    beat_cnt_d = '0;
                    state_d    = S_XFER;
                end else if (i_arb_empty && !wait_first) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q == WW'(WAIT_MAX - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_XFER: begin
                if (accept) begin
                    if (i_q_last[sel_q]) begin
                        state_d = S_CLR;
                    end else if (beat_cnt_q == BW'(MAXBEAT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_CLR;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_CLR: begin
                pkt_cnt_d  = pkt_cnt_q + 16'd1;
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath is a pure mux of the selected queue, so downstream stability follows the source.
    always_comb begin
        o_update   = (state_q == S_UPD);
        o_clr_vld  = (state_q == S_CLR);
        o_clr_port = (state_q == S_CLR) ? sel_q : '0;
        o_busy     = (state_q != S_IDLE);
        o_vld      = 1'b0;
        o_data     = '0;
        o_last     = 1'b0;
        o_port     = '0;
        o_q_rdy    = '0;
        if (state_q == S_XFER) begin
            o_vld          = i_q_vld[sel_q];
            o_data         = i_q_data[sel_q];
            o_last         = i_q_last[sel_q];
            o_port         = sel_q;
            o_q_rdy[sel_q] = i_ready;
        end
    end

endmodule

// File: tb/tb_que_dispatcher.sv
// Bench for que_dispatcher: queue/arbiter environment model driving the DUT,
// scenario table, randomized batches and hand-written corner sequences.
module tb_que_dispatcher;
    localparam int PN = 16;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int WM = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [PN-1:0]   pending;
    logic            o_update, o_clr_vld;
    logic [3:0]      o_clr_port;
    logic [3:0]      arb_port;
    logic            arb_vld, arb_empty;
    logic [PN-1:0]   q_vld, q_last, o_q_rdy;
    logic [DW-1:0]   q_data [PN];
    logic            o_vld, o_last, ready, o_busy, o_err;
    logic [DW-1:0]   o_data;
    logic [3:0]      o_port;
    logic [15:0]     o_pkt_cnt;

    que_dispatcher #(.PORTNUM(PN), .DW(DW), .MAXBEAT(MB), .WAIT_MAX(WM)) dut (
        .i_clk(clk), .i_rst(rst), .i_pending(pending),
        .o_update(o_update), .o_clr_vld(o_clr_vld), .o_clr_port(o_clr_port),
        .i_arb_port(arb_port), .i_arb_port_vld(arb_vld), .i_arb_empty(arb_empty),
        .i_q_vld(q_vld), .i_q_data(q_data), .i_q_last(q_last), .o_q_rdy(o_q_rdy),
        .o_vld(o_vld), .o_data(o_data), .o_last(o_last), .o_port(o_port),
        .i_ready(ready), .o_busy(o_busy), .o_pkt_cnt(o_pkt_cnt), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Environment: per-port FIFOs of {last, data} and a highest-index-first arbiter snapshot.
    logic [32:0]   mem [PN][16];
    int            hd [PN];
    int            tl [PN];
    logic [PN-1:0] snap, hold;
    bit            pkt_open, mute, tog, prev_stall, s_busy;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [3:0]    prev_port;
    logic [15:0]   base_cnt;
    int            ready_mode, vld_pct;
    int            n_upd, n_clr, n_beats, n_trunc, busy_cyc, first_clr;

    typedef struct {
        logic [15:0] mask;
        int nb;
        int rmode;
        int vpct;
        int exp_busy;
        int exp_pkts;
        int exp_beats;
        int exp_first;
    } vec_t;

    task automatic chk_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int hi_bit(input logic [PN-1:0] m);
        int r;
        r = -1;
        for (int i = 0; i < PN; i++) if (m[i]) r = i;
        return r;
    endfunction

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int p = 0; p < PN; p++) if (hd[p] != tl[p]) e = 1'b0;
        return e;
    endfunction

    task automatic push_pkt(input int p, input int nb, input bit with_last);
        if (hd[p] == tl[p]) begin
            hd[p] = 0;
            tl[p] = 0;
        end
        for (int k = 0; k < nb; k++) begin
            mem[p][tl[p]] = {with_last && (k == nb - 1), $urandom};
            tl[p]++;
        end
    endtask

    task automatic zero_inputs();
        pending = '0; q_vld = '0; q_last = '0; ready = 1'b0;
        arb_port = '0; arb_vld = 1'b0; arb_empty = 1'b0;
        for (int p = 0; p < PN; p++) q_data[p] = '0;
    endtask

    task automatic reset_env();
        for (int p = 0; p < PN; p++) begin
            hd[p] = 0;
            tl[p] = 0;
        end
        snap = '0; hold = '0; pkt_open = 1'b0; prev_stall = 1'b0; s_busy = 1'b0;
    endtask

    task automatic begin_scn();
        n_upd = 0; n_clr = 0; n_beats = 0; n_trunc = 0; busy_cyc = 0; first_clr = -1;
        base_cnt = o_pkt_cnt;
    endtask

    task automatic sample();
        int h;
        int p;
        bit inv;
        logic [32:0] b;
        h = hi_bit(snap);
        inv = !(o_update && o_clr_vld);
        if (o_q_rdy != '0) inv &= ready && o_busy && (o_q_rdy == (16'd1 << o_port));
        if (o_vld) inv &= (o_q_rdy == (ready ? (16'd1 << o_port) : 16'd0));
        if (!o_busy) inv &= !o_vld && !o_update && !o_clr_vld;
        if (prev_stall) inv &= o_vld && (o_data == prev_data) && (o_last == prev_last) && (o_port == prev_port);
        chk_eq("cycle_invariants", inv, 1'b1);
        if (o_vld && ready) begin
            p = int'(o_port);
            chk_eq("beat_port", o_port, h);
            chk_eq("beat_source_nonempty", hd[p] < tl[p], 1'b1);
            if (hd[p] < tl[p]) begin
                chk_eq("beat_data_last", {o_last, o_data}, mem[p][hd[p]]);
                hd[p]++;
            end
            n_beats++;
            pkt_open = !o_last;
        end
        for (int i = 0; i < PN; i++) hold[i] = q_vld[i] && !o_q_rdy[i];
        if (o_clr_vld) begin
            n_clr++;
            if (first_clr < 0) first_clr = int'(o_clr_port);
            chk_eq("clr_port", o_clr_port, h);
            if (pkt_open) begin
                n_trunc++;
                p = int'(o_clr_port);
                while (hd[p] < tl[p]) begin
                    b = mem[p][hd[p]];
                    hd[p]++;
                    if (b[32]) break;
                end
                hold[p] = 1'b0;
                pkt_open = 1'b0;
            end
            if (h >= 0) snap[h] = 1'b0;
        end
        if (o_update) begin
            n_upd++;
            snap = pending;
        end
        prev_stall = o_vld && !ready;
        prev_data = o_data; prev_last = o_last; prev_port = o_port;
        s_busy = o_busy;
        if (o_busy) busy_cyc++;
    endtask

    task automatic cycle();
        int h;
        @(negedge clk);
        for (int p = 0; p < PN; p++) begin
            if (hd[p] != tl[p]) begin
                pending[p] = 1'b1;
                q_vld[p]   = hold[p] || ($urandom_range(99) < vld_pct);
                q_data[p]  = mem[p][hd[p]][31:0];
                q_last[p]  = mem[p][hd[p]][32];
            end else begin
                pending[p] = 1'b0;
                q_vld[p]   = 1'b0;
                q_data[p]  = '0;
                q_last[p]  = 1'b0;
            end
        end
        tog = !tog;
        ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? tog : ($urandom_range(1) == 1);
        h = hi_bit(snap);
        arb_vld   = !mute && (h >= 0);
        arb_empty = !mute && (h < 0);
        arb_port  = (h >= 0) ? 4'(h) : 4'd0;
        #4;
        sample();
        @(posedge clk);
    endtask

    task automatic run_scn(input int budget, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        do begin
            cycle();
            n++;
            if (s_busy) seen = 1'b1;
        end while (!(seen && !s_busy && all_empty()) && n < budget);
        chk_eq({name, "_completed"}, seen && !s_busy && all_empty(), 1'b1);
        #1;
    endtask

    initial begin
        vec_t vt [6];
        int n, exp_p, exp_b, np, nb;
        bit seen;

        vt[0] = '{16'h0004, 3, 0, 100,  8, 1, 3,  2};
        vt[1] = '{16'h0220, 2, 0, 100, 11, 2, 4,  9};
        vt[2] = '{16'h8001, 1, 0, 100,  9, 2, 2, 15};
        vt[3] = '{16'h0004, 4, 0, 100,  9, 1, 4,  2};
        vt[4] = '{16'h0008, 3, 1,  60, -1, 1, 3,  3};
        vt[5] = '{16'h1248, 2, 2,  50, -1, 4, 8, 12};

        rst = 1'b1; mute = 1'b0; tog = 1'b0; ready_mode = 0; vld_pct = 100;
        zero_inputs();
        reset_env();
        repeat (2) @(posedge clk);
        #1;
        chk_eq("reset_ctrl_outputs", {o_update, o_clr_vld, o_clr_port, o_q_rdy, o_vld, o_last, o_port, o_busy, o_err}, '0);
        chk_eq("reset_data_cnt", {o_data, o_pkt_cnt}, '0);
        @(negedge clk) rst = 1'b0;

        for (int r = 0; r < 6; r++) begin
            begin_scn();
            for (int p = 0; p < PN; p++) if (vt[r].mask[p]) push_pkt(p, vt[r].nb, 1'b1);
            ready_mode = vt[r].rmode;
            vld_pct = vt[r].vpct;
            run_scn(600, $sformatf("vec%0d", r));
            if (vt[r].exp_busy >= 0) chk_eq($sformatf("vec%0d_busy_cycles", r), busy_cyc, vt[r].exp_busy);
            chk_eq($sformatf("vec%0d_pkt_cnt", r), 16'(o_pkt_cnt - base_cnt), vt[r].exp_pkts);
            chk_eq($sformatf("vec%0d_beats", r), n_beats, vt[r].exp_beats);
            chk_eq($sformatf("vec%0d_first_port", r), first_clr, vt[r].exp_first);
            chk_eq($sformatf("vec%0d_updates", r), n_upd, 1);
            chk_eq($sformatf("vec%0d_err", r), o_err, 1'b0);
        end

        for (int b = 0; b < 4; b++) begin
            begin_scn();
            exp_p = 0;
            exp_b = 0;
            for (int p = 0; p < PN; p++) begin
                if ($urandom_range(2) == 0 || (p == 3 * b && exp_p == 0)) begin
                    np = $urandom_range(1, 2);
                    for (int k = 0; k < np; k++) begin
                        nb = $urandom_range(1, MB);
                        push_pkt(p, nb, 1'b1);
                        exp_p++;
                        exp_b += nb;
                    end
                end
            end
            ready_mode = $urandom_range(2);
            vld_pct = $urandom_range(40, 100);
            run_scn(4000, "rand");
            chk_eq("rand_pkt_cnt", 16'(o_pkt_cnt - base_cnt), exp_p);
            chk_eq("rand_beats", n_beats, exp_b);
            chk_eq("rand_err_trunc", {o_err, n_trunc[7:0]}, '0);
        end

        // Packet with no last beat: truncated at MAXBEAT beats.
        begin_scn();
        ready_mode = 0; vld_pct = 100;
        push_pkt(6, 6, 1'b0);
        run_scn(200, "trunc");
        chk_eq("trunc_beats", n_beats, MB);
        chk_eq("trunc_pkt_cnt", 16'(o_pkt_cnt - base_cnt), 1);
        chk_eq("trunc_clr_pulses", n_clr, 1);
        chk_eq("trunc_detected", n_trunc, 1);
        chk_eq("trunc_err", o_err, 1'b1);

        // Reset while the second beat of a five-beat packet is on the bus.
        begin_scn();
        push_pkt(4, 5, 1'b1);
        n = 0;
        while (n_beats < 1 && n < 20) begin
            cycle();
            n++;
        end
        chk_eq("rst_reached_beat2", n_beats, 1);
        #2;
        chk_eq("pre_reset_busy", o_busy, 1'b1);
        rst = 1'b1;
        #1;
        chk_eq("midpkt_reset_ctrl", {o_update, o_clr_vld, o_clr_port, o_q_rdy, o_vld, o_last, o_port, o_busy, o_err}, '0);
        chk_eq("midpkt_reset_data_cnt", {o_data, o_pkt_cnt}, '0);
        zero_inputs();
        reset_env();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        cycle();
        cycle();
        #1;
        chk_eq("after_reset_idle", {o_busy, o_pkt_cnt, o_err, n_clr[7:0]}, '0);

        // Grant never arrives and the arbiter never reports empty.
        begin_scn();
        mute = 1'b1;
        push_pkt(3, 1, 1'b1);
        seen = 1'b0;
        n = 0;
        while (!(seen && !s_busy) && n < 40) begin
            cycle();
            n++;
            if (s_busy) seen = 1'b1;
        end
        chk_eq("timeout_back_idle", seen && !s_busy, 1'b1);
        hd[3] = 0; tl[3] = 0; snap = '0; mute = 1'b0;
        #1;
        chk_eq("timeout_busy_cycles", busy_cyc, 5);
        chk_eq("timeout_err", o_err, 1'b1);
        chk_eq("timeout_updates", n_upd, 1);
        chk_eq("timeout_no_traffic", n_beats + n_clr, 0);
        repeat (6) cycle();
        #1;
        chk_eq("timeout_settled", {o_busy, o_err}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
